fsm_exemem: RTL and testbench
=============================

# fsm_exemem

Self-contained execute/memory-stage demonstrator. A small control FSM drives a 256 x 16 true dual-port RAM. After reset it writes 69 to address 1 through port 1 and 21 to address 3 through port 2 in the same cycle. It then reads both locations back and presents them on two output buses. It serves as the bring-up block for the datapath's memory stage.

## Interface
- No parameters. Fixed values: ADDR_W = 8, DATA_W = 16, A1 = 8'd1, D1 = 16'd69, A2 = 8'd3, D2 = 16'd21.
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dataOut1  out  16  registered read data from RAM port 1.
- dataOut2  out  16  registered read data from RAM port 2.

## Operation
- The RAM is instantiated with instance name `memory`. Its port signals are named exactly as follows, so benches can probe them hierarchically:
  - we1, addr1[7:0], dataIn1[15:0], q1[15:0]
  - we2, addr2[7:0], dataIn2[15:0], q2[15:0]
- dataOut1 = memory.q1; dataOut2 = memory.q2.
- FSM states (2-bit encoding):
  - S_WRITE (00)
    - Port 1: we1 = 1, addr1 = 1, dataIn1 = 69.
    - Port 2: we2 = 1, addr2 = 3, dataIn2 = 21.
    - Next state: S_READ.
  - S_READ (01)
    - we1 = we2 = 0, addr1 = 1, addr2 = 3, dataIn1 = dataIn2 = 0.
    - Next state: S_DONE.
  - S_DONE (10)
    - Same outputs as S_READ.
    - Stays in S_DONE until reset.
  - Code 11 is illegal and goes to S_WRITE next.
- reset forces the state to S_WRITE.
- we1/we2 are asserted only in S_WRITE. No other write ever reaches the RAM; exactly one write per port per reset release.
- RAM behaviour:
  - Writes are synchronous on a clock edge with we high.
  - Reads are synchronous: q registers mem[addr] every cycle.
  - Read-during-write on the same port returns the old data.
  - When both ports write the same address in the same cycle, port 2 wins. The FSM never does this, but the RAM must still behave so.
  - The array is not cleared by reset; only q1/q2 are cleared to 0.

## Timing
- Edge E0: reset sampled high. State becomes S_WRITE and dataOut1 = dataOut2 = 0.
- Cycle after E0 with reset low: we1 = we2 = 1 combinationally.
- Edge E1: mem[1] = 69, mem[3] = 21. State becomes S_READ. q holds old contents (read-old).
- Edge E2: q1 = 69, q2 = 21. State becomes S_DONE.
- From E2 on, dataOut1 = 69 and dataOut2 = 21, stable indefinitely. Latency from reset release to valid outputs is 2 edges.
- Reset asserted mid-operation: on the next edge, state = S_WRITE and outputs = 0. RAM contents are kept. The sequence then repeats after release, and the rewrite is idempotent.
- reset held high: stays in S_WRITE with we forced 0 while reset is high, so no write occurs during reset.
- Before the first reset, state is undefined. No requirement applies until reset has been sampled.

## Structure
- Package `exemem_pkg` holds:
  - ADDR_W and DATA_W
  - the state enum (S_WRITE, S_READ, S_DONE)
  - constants A1, D1, A2, D2
- One sub-module, `dual_port_ram`: 256 x 16, two independent read/write ports, synchronous read, reset on the q registers only. It is instantiated once as `memory`.
- The FSM (state register plus combinational port-control decode) lives in the top level.

## Test plan
- Reset 1 cycle, then release:
  - exactly one cycle with memory.we1 = 1, addr1 = 1, dataIn1 = 69.
  - in the same cycle, memory.we2 = 1, addr2 = 3, dataIn2 = 21.
  - any other we assertion is a failure.
- 2 edges after release: dataOut1 = 16'd69 and dataOut2 = 16'd21. Both hold for 100 further cycles with no we activity.
- During reset: dataOut1 = dataOut2 = 0 and we1 = we2 = 0.
- Reset pulse in S_DONE:
  - outputs drop to 0 on that edge.
  - a single write cycle repeats.
  - outputs return to 69/21 two edges after release.
- Reset held 5 cycles: no writes occur; the write happens only in the first cycle after release.
- RAM unit test:
  - simultaneous write to the same address from both ports leaves port-2 data.
  - read-during-write on one port returns old data, then new data on the following read.

Source files
------------

// File: rtl/exemem_pkg.sv
// Shared widths, FSM state encoding and the fixed write pattern for the
// execute/memory-stage bring-up block.
package exemem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] A1 = 8'd1;
  localparam logic [DATA_W-1:0] D1 = 16'd69;
  localparam logic [ADDR_W-1:0] A2 = 8'd3;
  localparam logic [DATA_W-1:0] D2 = 16'd21;

  typedef enum logic [1:0] {
    S_WRITE = 2'b00,
    S_READ  = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/dual_port_ram.sv
// 256 x 16 true dual-port RAM: synchronous read with read-old-data behaviour,
// port 2 wins a same-address write collision, only the read registers reset.
module dual_port_ram
  import exemem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dataIn1,
  output logic [DATA_W-1:0] q1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] dataIn2,
  output logic [DATA_W-1:0] q2
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Port 2 is assigned last so its value survives a same-address collision.
  always_ff @(posedge clk) begin
    if (we1) mem_q[addr1] <= dataIn1;
    if (we2) mem_q[addr2] <= dataIn2;
  end

  // Non-blocking reads of mem_q see the pre-write contents: read-old behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= mem_q[addr1];
      q2 <= mem_q[addr2];
    end
  end

endmodule

// File: rtl/fsm_exemem.sv
// Memory-stage demonstrator: writes two fixed words once after reset release,
// then continuously reads them back onto the output buses.
module fsm_exemem
  import exemem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] dataOut1,
  output logic [DATA_W-1:0] dataOut2
);

  state_e state_q, state_d;

  logic              we1, we2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [DATA_W-1:0] dataIn1, dataIn2;
  logic [DATA_W-1:0] q1, q2;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WRITE;
    else       state_q <= state_d;
  end

  // Write enables are gated by reset so holding reset never touches the RAM.
  always_comb begin
    state_d = S_WRITE;
    we1     = 1'b0;
    we2     = 1'b0;
    addr1   = A1;
    addr2   = A2;
    dataIn1 = '0;
    dataIn2 = '0;
    case (state_q)
      S_WRITE: begin
        we1     = ~reset;
        we2     = ~reset;
        dataIn1 = D1;
        dataIn2 = D2;
        state_d = S_READ;
      end
      S_READ:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WRITE;
    endcase
  end

  dual_port_ram memory (
    .clk     (clk),
    .reset   (reset),
    .we1     (we1),
    .addr1   (addr1),
    .dataIn1 (dataIn1),
    .q1      (q1),
    .we2     (we2),
    .addr2   (addr2),
    .dataIn2 (dataIn2),
    .q2      (q2)
  );

  assign dataOut1 = q1;
  assign dataOut2 = q2;

endmodule

// File: tb/tb_fsm_exemem.sv
// Self-checking bench for fsm_exemem: randomized reset schedules against a
// cycle-level reference model, plus a direct unit test of the dual-port RAM.
module tb_fsm_exemem;
  import exemem_pkg::*;

  localparam int W = 35; // {care_out, we1, we2, out1[15:0], out2[15:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] dataOut1, dataOut2;

  // ---- clock / reset block
  always #5 clk = ~clk;

  fsm_exemem dut (
    .clk      (clk),
    .reset    (reset),
    .dataOut1 (dataOut1),
    .dataOut2 (dataOut2)
  );

  // Standalone RAM for collision and read-during-write checks.
  logic        ut_rst = 1'b1;
  logic        ut_we1 = 1'b0, ut_we2 = 1'b0;
  logic [7:0]  ut_a1 = '0, ut_a2 = '0;
  logic [15:0] ut_d1 = '0, ut_d2 = '0;
  logic [15:0] ut_q1, ut_q2;

  dual_port_ram ram_ut (
    .clk (clk), .reset (ut_rst),
    .we1 (ut_we1), .addr1 (ut_a1), .dataIn1 (ut_d1), .q1 (ut_q1),
    .we2 (ut_we2), .addr2 (ut_a2), .dataIn2 (ut_d2), .q2 (ut_q2)
  );

  // ---- scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: RAM words 1 and 3 plus edges since reset release
  logic [15:0] m1, m2;
  bit          m_known = 0;
  bit          seen_rst = 0;
  int          since_rel = 0;
  logic        exp_o_care;
  logic [15:0] exp_o1, exp_o2;

  // Advance one edge with the reset value sampled there, then present the next
  // reset value and queue what the DUT should show during the following cycle.
  task automatic step(input logic next_rst);
    logic rs;
    logic exp_we;
    @(posedge clk);
    rs = reset;
    if (rs) begin
      seen_rst   = 1;
      since_rel  = 0;
      exp_o_care = 1'b1;
      exp_o1     = '0;
      exp_o2     = '0;
    end else if (seen_rst) begin
      exp_o_care = m_known;
      exp_o1     = m1;
      exp_o2     = m2;
      if (since_rel == 0) begin
        m1 = D1;
        m2 = D2;
        m_known = 1;
      end
      if (since_rel < 1000) since_rel++;
    end
    #1;
    reset = next_rst;
    if (seen_rst) begin
      exp_we = (since_rel == 0) && !next_rst;
      exp_q.push_back({exp_o_care, exp_we, exp_we, exp_o1, exp_o2});
    end
  endtask

  // ---- monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("we1", 16'(dut.memory.we1), 16'(e[33]));
        chk("we2", 16'(dut.memory.we2), 16'(e[32]));
        chk("addr1", 16'(dut.memory.addr1), 16'(A1));
        chk("addr2", 16'(dut.memory.addr2), 16'(A2));
        if (e[33]) chk("dataIn1", dut.memory.dataIn1, D1);
        if (e[32]) chk("dataIn2", dut.memory.dataIn2, D2);
        if (e[34]) begin
          chk("dataOut1", dataOut1, e[31:16]);
          chk("dataOut2", dataOut2, e[15:0]);
        end
      end
    end
  end

  // ---- driver
  task automatic run(input int n_rst, input int n_run);
    for (int i = 0; i < n_rst; i++) step(1'b1);
    for (int i = 0; i < n_run; i++) step(1'b0);
  endtask

  task automatic ram_unit_test();
    @(negedge clk);
    ut_rst = 1'b0;
    ut_we1 = 1'b1; ut_a1 = 8'd5; ut_d1 = 16'hAAAA;
    ut_we2 = 1'b1; ut_a2 = 8'd5; ut_d2 = 16'h5555;
    @(negedge clk);
    ut_we1 = 1'b0; ut_we2 = 1'b0;
    @(negedge clk);
    chk("ram_collision_q1", ut_q1, 16'h5555);
    chk("ram_collision_q2", ut_q2, 16'h5555);
    ut_we1 = 1'b1; ut_d1 = 16'h1234;
    @(negedge clk);
    chk("ram_rdw_old", ut_q1, 16'h5555);
    ut_we1 = 1'b0;
    @(negedge clk);
    chk("ram_rdw_new", ut_q1, 16'h1234);
    chk("ram_port2_sees_new", ut_q2, 16'h1234);
    ut_rst = 1'b1;
    @(negedge clk);
    chk("ram_reset_q1", ut_q1, 16'h0000);
    chk("ram_reset_q2", ut_q2, 16'h0000);
  endtask

  initial begin
    ram_unit_test();
    run(1, 103);   // first bring-up and long hold
    run(1, 20);    // reset pulse while in S_DONE
    run(5, 10);    // reset held for several cycles
    for (int k = 0; k < 8; k++)
      run($urandom_range(1, 4), $urandom_range(0, 25));
    step(1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
